mem_arbiter: RTL

Line-refill controller and arbiter sharing the single backing memory between the instruction cache (port 0) and the data cache (port 1). It accepts one 4-word line request at a time, sequences the word beats on the memory bus, absorbs the fixed memory read latency, and returns the assembled 128-bit line with a one-cycle completion pulse. Ties are resolved round-robin.

---
 rtl/mem_arb_pkg.sv | 27 ++
 rtl/mem_arbiter_rr_arb2.sv | 38 +++
 rtl/mem_arbiter.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the line-refill arbiter.
//   state_e    : controller states
//   BEATS      : words per cache line
//   ADDR_W/WORD_W/LINE_W : bus and line widths
//   beat_addr(): byte address of word k within a line
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int BEATS  = 4;
  localparam int ADDR_W = 12;
  localparam int WORD_W = 32;
  localparam int LINE_W = 128;

  localparam logic [1:0] BEAT_LAST = 2'(BEATS - 1);

  function automatic logic [ADDR_W-1:0] beat_addr(input logic [7:0] line,
                                                  input logic [1:0] k);
    return {line, k, 2'b00};
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter with a last-grant flop.
//   clk_i, rst_ni : clock, async active-low reset (last grant -> port 0)
//   req_i[1:0]    : pending requests
//   upd_i         : load upd_port_i as the most recently served port
//   gnt_vld_o     : at least one request pending
//   gnt_port_o    : port to serve (combinational from req_i and last grant)
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  input  logic       upd_port_i,
  output logic       gnt_vld_o,
  output logic       gnt_port_o
);

  logic last_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= 1'b0;
    end else if (upd_i) begin
      last_q <= upd_port_i;
    end
  end

  always_comb begin
    gnt_vld_o  = |req_i;
    gnt_port_o = 1'b0;
    unique case (req_i)
      2'b01:   gnt_port_o = 1'b0;
      2'b10:   gnt_port_o = 1'b1;
      2'b11:   gnt_port_o = ~last_q;  // tie goes to the port not served last
      default: gnt_port_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Line-refill controller sharing one backing memory between the I-cache
// (port 0) and the D-cache (port 1). One 4-word line transfer at a time:
// beats are issued on consecutive cycles, read data is captured LAT cycles
// after each beat, and the finished line is returned with a DONE pulse.
//
// state | meaning
// IDLE  | sample REQ0/REQ1, grant one, latch request
// ISSUE | one memory beat per cycle, words 0..3
// DRAIN | wait for the last read word to come back
// DONE  | pulse DONE of granted port, update round-robin flag
//
// Ports:
//   CLK, RSTn              : clock, async active-low reset
//   REQx, WEx, ADDRx, WDATAx : line request from port x (level, held to DONE)
//   RDATAx, DONEx          : refill line and completion pulse to port x
//   BUSY                   : controller not idle
//   M_CSN, M_WEN, M_ADDR, M_BE, M_DI : registered memory command bus
//   M_DO                   : memory read data, valid LAT cycles after a beat
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int LAT = 2
) (
  input  logic                CLK,
  input  logic                RSTn,
  input  logic                REQ0,
  input  logic                REQ1,
  input  logic                WE0,
  input  logic                WE1,
  input  logic [ADDR_W-1:0]   ADDR0,
  input  logic [ADDR_W-1:0]   ADDR1,
  input  logic [LINE_W-1:0]   WDATA0,
  input  logic [LINE_W-1:0]   WDATA1,
  output logic [LINE_W-1:0]   RDATA0,
  output logic [LINE_W-1:0]   RDATA1,
  output logic                DONE0,
  output logic                DONE1,
  output logic                BUSY,
  output logic                M_CSN,
  output logic                M_WEN,
  output logic [ADDR_W-1:0]   M_ADDR,
  output logic [3:0]          M_BE,
  output logic [WORD_W-1:0]   M_DI,
  input  logic [WORD_W-1:0]   M_DO
);

  state_e              state_q;
  logic [1:0]          beat_q;
  logic [1:0]          cap_k_q;
  logic [LAT-1:0]      cap_pipe_q;
  logic [LAT-1:0]      cap_pipe_d;
  logic                port_q;
  logic                we_q;
  logic [7:0]          line_addr_q;
  logic [LINE_W-1:0]   wdata_q;
  logic [3*WORD_W-1:0] rbuf_q;
  logic                csn_q;
  logic                wen_q;
  logic [3:0]          be_q;
  logic [ADDR_W-1:0]   maddr_q;
  logic [WORD_W-1:0]   di_q;
  logic                done0_q;
  logic                done1_q;
  logic                busy_q;
  logic [LINE_W-1:0]   rdata0_q;
  logic [LINE_W-1:0]   rdata1_q;

  logic                gnt_vld;
  logic                gnt_port;
  logic                sel_we;
  logic [7:0]          sel_line;
  logic [LINE_W-1:0]   sel_wdata;
  logic                rd_beat;
  logic                cap_now;
  logic [1:0]          beat_nxt;
  logic                unused_addr_bits;

  assign unused_addr_bits = ^{ADDR0[3:0], ADDR1[3:0]};

  rr_arb2 u_rr_arb2 (
    .clk_i      (CLK),
    .rst_ni     (RSTn),
    .req_i      ({REQ1, REQ0}),
    .upd_i      (state_q == DONE),
    .upd_port_i (port_q),
    .gnt_vld_o  (gnt_vld),
    .gnt_port_o (gnt_port)
  );

  assign sel_we    = gnt_port ? WE1 : WE0;
  assign sel_line  = gnt_port ? ADDR1[11:4] : ADDR0[11:4];
  assign sel_wdata = gnt_port ? WDATA1 : WDATA0;
  assign beat_nxt  = beat_q + 2'd1;

  // A read beat on the bus this cycle returns on M_DO exactly LAT cycles
  // later; the delay line tags those return cycles.
  assign rd_beat = ~csn_q & wen_q;
  assign cap_now = cap_pipe_q[LAT-1];

  always_comb begin
    cap_pipe_d    = '0;
    cap_pipe_d[0] = rd_beat;
    for (int i = 1; i < LAT; i++) begin
      cap_pipe_d[i] = cap_pipe_q[i-1];
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      cap_k_q     <= '0;
      cap_pipe_q  <= '0;
      port_q      <= 1'b0;
      we_q        <= 1'b0;
      line_addr_q <= '0;
      wdata_q     <= '0;
      rbuf_q      <= '0;
      csn_q       <= 1'b1;
      wen_q       <= 1'b1;
      be_q        <= '0;
      maddr_q     <= '0;
      di_q        <= '0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      busy_q      <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      cap_pipe_q <= cap_pipe_d;

      // Words 0..2 park in the buffer; word 3 goes straight into RDATA.
      if (cap_now) begin
        cap_k_q <= cap_k_q + 2'd1;
        unique case (cap_k_q)
          2'd0:    rbuf_q[31:0]  <= M_DO;
          2'd1:    rbuf_q[63:32] <= M_DO;
          2'd2:    rbuf_q[95:64] <= M_DO;
          default: ;
        endcase
      end

      unique case (state_q)
        IDLE: begin
          if (gnt_vld) begin
            port_q      <= gnt_port;
            we_q        <= sel_we;
            line_addr_q <= sel_line;
            wdata_q     <= sel_wdata;
            beat_q      <= '0;
            cap_k_q     <= '0;
            csn_q       <= 1'b0;
            wen_q       <= ~sel_we;
            be_q        <= 4'hF;
            maddr_q     <= beat_addr(sel_line, 2'd0);
            di_q        <= sel_wdata[WORD_W-1:0];
            busy_q      <= 1'b1;
            state_q     <= ISSUE;
          end
        end

        ISSUE: begin
          if (beat_q == BEAT_LAST) begin
            csn_q   <= 1'b1;
            wen_q   <= 1'b1;
            be_q    <= '0;
            maddr_q <= '0;
            di_q    <= '0;
            if (we_q) begin
              done0_q <= ~port_q;
              done1_q <= port_q;
              state_q <= DONE;
            end else begin
              state_q <= DRAIN;
            end
          end else begin
            beat_q  <= beat_nxt;
            maddr_q <= beat_addr(line_addr_q, beat_nxt);
            di_q    <= wdata_q[{beat_nxt, 5'b0} +: WORD_W];
          end
        end

        DRAIN: begin
          if (cap_now && (cap_k_q == BEAT_LAST)) begin
            done0_q <= ~port_q;
            done1_q <= port_q;
            if (port_q) begin
              rdata1_q <= {M_DO, rbuf_q};
            end else begin
              rdata0_q <= {M_DO, rbuf_q};
            end
            state_q <= DONE;
          end
        end

        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign RDATA0 = rdata0_q;
  assign RDATA1 = rdata1_q;
  assign DONE0  = done0_q;
  assign DONE1  = done1_q;
  assign BUSY   = busy_q;
  assign M_CSN  = csn_q;
  assign M_WEN  = wen_q;
  assign M_ADDR = maddr_q;
  assign M_BE   = be_q;
  assign M_DI   = di_q;

endmodule
